// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: the result packet carried from an FU queue to the bus.
package cdb_arbiter_pkg;

    localparam int CDB_PHYS_W = 6;
    localparam int CDB_ROB_W  = 6;
    localparam int CDB_VAL_W  = 64;

    typedef struct packed {
        logic [CDB_PHYS_W-1:0] tag;
        logic [CDB_VAL_W-1:0]  value;
        logic [CDB_ROB_W-1:0]  rob_tag;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result handshake and CDB broadcast bundle; slave = arbiter side, master = FU/consumer side.
interface cdb_arbiter_if #(
    parameter int NUM_FU = 4,
    parameter int CDB_W  = 2,
    parameter int PHYS_W = cdb_arbiter_pkg::CDB_PHYS_W
);
    logic [NUM_FU-1:0]                                   fu_valid;
    logic [NUM_FU-1:0]                                   fu_ready;
    logic [NUM_FU-1:0][PHYS_W-1:0]                       fu_tag;
    logic [NUM_FU-1:0][cdb_arbiter_pkg::CDB_VAL_W-1:0]   fu_value;
    logic [NUM_FU-1:0][cdb_arbiter_pkg::CDB_ROB_W-1:0]   fu_rob_tag;
    logic [CDB_W-1:0]                                    cdb_valid;
    logic [CDB_W-1:0][PHYS_W-1:0]                        cdb_tag;
    logic [CDB_W-1:0][cdb_arbiter_pkg::CDB_VAL_W-1:0]    cdb_value;
    logic [CDB_W-1:0][cdb_arbiter_pkg::CDB_ROB_W-1:0]    cdb_rob_tag;

    modport slave (
        input  fu_valid, fu_tag, fu_value, fu_rob_tag,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
    );

    modport master (
        output fu_valid, fu_tag, fu_value, fu_rob_tag,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
    );
endinterface

// File: rtl/cdb_result_fifo.sv
// Per-FU result queue: power-of-2 depth, registered full/empty, synchronous clear for flush.
module cdb_result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clr,
    input  logic     push,
    input  cdb_pkt_t push_pkt,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output cdb_pkt_t head
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cdb_pkt_t         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !clr;
        do_pop   = pop && !empty && !clr;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (do_push) mem_q[wr_ptr_q] <= push_pkt;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-FU result queues, round-robin pick of up to CDB_W results, registered broadcast.
// Optional build macro CDB_ARB_STATS_EN adds saturating broadcast / backpressure counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int CDB_W      = 2,
    parameter int PHYS_W     = CDB_PHYS_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_pipeline,
    cdb_arbiter_if.slave      bus
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]       stat_bcast_cnt,
    output logic [31:0]       stat_full_cnt
`endif
);
    localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    cdb_pkt_t                push_pkt [NUM_FU];
    cdb_pkt_t                head     [NUM_FU];
    logic [NUM_FU-1:0]       full, empty, pop;
    logic [RR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CDB_W-1:0]        cdb_valid_q, cdb_valid_d;
    cdb_pkt_t [CDB_W-1:0]    cdb_pkt_q, cdb_pkt_d;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        assign push_pkt[g] = '{tag: bus.fu_tag[g], value: bus.fu_value[g], rob_tag: bus.fu_rob_tag[g]};

        cdb_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .clr      (flush_pipeline),
            .push     (bus.fu_valid[g]),
            .push_pkt (push_pkt[g]),
            .pop      (pop[g]),
            .full     (full[g]),
            .empty    (empty[g]),
            .head     (head[g])
        );
    end

    assign bus.fu_ready = ~full;

    // Scan FUs from rr_ptr upward; each hit takes the next free slot, so slots fill in order.
    always_comb begin
        int n;
        int last;
        n           = 0;
        last        = 0;
        pop         = '0;
        cdb_valid_d = '0;
        cdb_pkt_d   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            for (int g = 0; g < NUM_FU; g++) begin
                if (g == (int'(rr_ptr_q) + k) % NUM_FU && !empty[g] && n < CDB_W) begin
                    pop[g] = 1'b1;
                    for (int s = 0; s < CDB_W; s++) begin
                        if (s == n) begin
                            cdb_valid_d[s] = 1'b1;
                            cdb_pkt_d[s]   = head[g];
                        end
                    end
                    last = g;
                    n    = n + 1;
                end
            end
        end
        rr_ptr_d = (n != 0) ? RR_W'((last + 1) % NUM_FU) : rr_ptr_q;
        if (flush_pipeline) begin
            cdb_valid_d = '0;
            cdb_pkt_d   = '0;
            rr_ptr_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_pkt_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_pkt_q   <= cdb_pkt_d;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    for (genvar s = 0; s < CDB_W; s++) begin : g_slot
        assign bus.cdb_tag[s]     = cdb_pkt_q[s].tag;
        assign bus.cdb_value[s]   = cdb_pkt_q[s].value;
        assign bus.cdb_rob_tag[s] = cdb_pkt_q[s].rob_tag;
    end

`ifdef CDB_ARB_STATS_EN
    logic [31:0] bcast_cnt_q, bcast_cnt_d;
    logic [31:0] full_cnt_q, full_cnt_d;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

    // Counters survive flush; only reset clears them.
    always_comb begin
        bcast_cnt_d = sat_add(bcast_cnt_q, 32'($countones(cdb_valid_d)));
        full_cnt_d  = (|full) ? sat_add(full_cnt_q, 32'd1) : full_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcast_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            bcast_cnt_q <= bcast_cnt_d;
            full_cnt_q  <= full_cnt_d;
        end
    end

    assign stat_bcast_cnt = bcast_cnt_q;
    assign stat_full_cnt  = full_cnt_q;
`endif

endmodule
